// File: rtl/bus_arb_2_pkg.sv
// bus_arb_2_pkg: shared bus types for the memory-port arbiter (FSM states, requester indices, byte-enable width)
package bus_arb_2_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RSP = 2'd2} state_e;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
  localparam int BE_W = 4;
endpackage

// File: rtl/bus_arb_2_mux.sv
// MUX_2: library 2:1 mux (I_SEL picks I_D1 when high, else I_D0; result on O_D)
module MUX_2 #(
  parameter int DW = 32
) (
  input  logic          I_SEL,
  input  logic [DW-1:0] I_D0,
  input  logic [DW-1:0] I_D1,
  output logic [DW-1:0] O_D
);
  assign O_D = I_SEL ? I_D1 : I_D0;
endmodule

// File: rtl/bus_arb_2.sv
// bus_arb_2: round-robin fetch/LSU arbiter onto one memory port (ports: two requester cmd/gnt/rsp sets in, latched req/gnt/rvalid memory port out)
module bus_arb_2
  import bus_arb_2_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            I_CLK,
  input  logic            I_RSTN,
  input  logic            I_REQ0,
  input  logic            I_REQ1,
  input  logic            I_WE0,
  input  logic            I_WE1,
  input  logic [BE_W-1:0] I_BE0,
  input  logic [BE_W-1:0] I_BE1,
  input  logic [AW-1:0]   I_ADDR0,
  input  logic [AW-1:0]   I_ADDR1,
  input  logic [DW-1:0]   I_WDATA0,
  input  logic [DW-1:0]   I_WDATA1,
  output logic            O_GNT0,
  output logic            O_GNT1,
  output logic            O_RVALID0,
  output logic            O_RVALID1,
  output logic [DW-1:0]   O_RDATA0,
  output logic [DW-1:0]   O_RDATA1,
  output logic            O_M_REQ,
  output logic            O_M_WE,
  output logic [BE_W-1:0] O_M_BE,
  output logic [AW-1:0]   O_M_ADDR,
  output logic [DW-1:0]   O_M_WDATA,
  input  logic            I_M_GNT,
  input  logic            I_M_RVALID,
  input  logic [DW-1:0]   I_M_RDATA
);
  state_e          state_q;
  logic            owner_q, last_q, any, win, idle, rsp;
  logic            we_w;
  logic [BE_W-1:0] be_w;
  logic [AW-1:0]   addr_w;
  logic [DW-1:0]   wdata_w;
  assign any  = I_REQ0 | I_REQ1;
  assign win  = (I_REQ0 & I_REQ1) ? ~last_q : I_REQ1;
  assign idle = state_q == ST_IDLE;
  assign rsp  = state_q == ST_RSP;
  MUX_2 #(.DW(AW))   u_addr  (.I_SEL(win), .I_D0(I_ADDR0),  .I_D1(I_ADDR1),  .O_D(addr_w));
  MUX_2 #(.DW(DW))   u_wdata (.I_SEL(win), .I_D0(I_WDATA0), .I_D1(I_WDATA1), .O_D(wdata_w));
  MUX_2 #(.DW(BE_W)) u_be    (.I_SEL(win), .I_D0(I_BE0),    .I_D1(I_BE1),    .O_D(be_w));
  MUX_2 #(.DW(1))    u_we    (.I_SEL(win), .I_D0(I_WE0),    .I_D1(I_WE1),    .O_D(we_w));
  assign O_GNT0    = I_RSTN & idle & any & (win == REQ_IF);
  assign O_GNT1    = I_RSTN & idle & any & (win == REQ_LS);
  assign O_M_REQ   = state_q == ST_CMD;
  assign O_RVALID0 = rsp & I_M_RVALID & (owner_q == REQ_IF);
  assign O_RVALID1 = rsp & I_M_RVALID & (owner_q == REQ_LS);
  assign O_RDATA0  = I_M_RDATA;
  assign O_RDATA1  = I_M_RDATA;
  always_ff @(posedge I_CLK or negedge I_RSTN)
    if (!I_RSTN) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_IF;
      last_q    <= REQ_LS;
      O_M_WE    <= 1'b0;
      O_M_BE    <= '0;
      O_M_ADDR  <= '0;
      O_M_WDATA <= '0;
    end else if (idle && any) begin
      state_q   <= ST_CMD;
      owner_q   <= win;
      last_q    <= win;
      O_M_WE    <= we_w;
      O_M_BE    <= be_w;
      O_M_ADDR  <= addr_w;
      O_M_WDATA <= wdata_w;
    end else if (O_M_REQ && I_M_GNT)
      state_q <= ST_RSP;
    else if (rsp && I_M_RVALID)
      state_q <= ST_IDLE;
endmodule

// File: tb/tb_bus_arb_2.sv
module tb_bus_arb_2;
  logic clk = 1'b0, rstn;
  logic req0, req1, we0, we1, gnt0, gnt1, rv0, rv1;
  logic [3:0] be0, be1, m_be;
  logic [31:0] addr0, addr1, wdata0, wdata1, rd0, rd1;
  logic m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int errors = 0, checks = 0;

  bus_arb_2 dut (
    .I_CLK(clk), .I_RSTN(rstn),
    .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_BE0(be0), .I_BE1(be1), .I_ADDR0(addr0), .I_ADDR1(addr1),
    .I_WDATA0(wdata0), .I_WDATA1(wdata1),
    .O_GNT0(gnt0), .O_GNT1(gnt1), .O_RVALID0(rv0), .O_RVALID1(rv1),
    .O_RDATA0(rd0), .O_RDATA1(rd1),
    .O_M_REQ(m_req), .O_M_WE(m_we), .O_M_BE(m_be), .O_M_ADDR(m_addr), .O_M_WDATA(m_wdata),
    .I_M_GNT(m_gnt), .I_M_RVALID(m_rvalid), .I_M_RDATA(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; be0 = 4'hf; be1 = 4'hf;
    addr0 = 32'h1234; addr1 = 32'h5678; wdata0 = 32'h1; wdata1 = 32'h2;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1}); end
    checks++; if ({m_req, rv0, rv1} !== 3'b000) begin errors++; $display("FAIL reset_req_rvalid got=%b exp=000", {m_req, rv0, rv1}); end
    checks++; if ({m_we, m_be, m_addr, m_wdata} !== 69'd0) begin errors++; $display("FAIL reset_fields got=%0h exp=0", {m_we, m_be, m_addr, m_wdata}); end
    req0 = 1'b0; req1 = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_tie();
    int gc[$];
    logic gw[$];
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      m_gnt = m_req; m_rvalid = ~m_req;
      @(negedge clk);
      if (gnt0) begin gc.push_back(c); gw.push_back(1'b0); end
      if (gnt1) begin gc.push_back(c); gw.push_back(1'b1); end
      if (c == 11) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end
    m_gnt = 1'b0; m_rvalid = 1'b0;
    checks++;
    if (gc.size() != 4) begin errors++; $display("FAIL tie_count got=%0d exp=4", gc.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (gw[i] !== i[0]) begin errors++; $display("FAIL tie_order[%0d] got=%0d exp=%0d", i, gw[i], i[0]); end
      checks++; if (gc[i] != 3 * i) begin errors++; $display("FAIL tie_gap[%0d] got=%0d exp=%0d", i, gc[i], 3 * i); end
    end
  endtask

  task automatic test_single_fetch();
    req0 = 1'b1; addr0 = 32'h0000_0100; we0 = 1'b0; be0 = 4'hf;
    @(negedge clk);
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got=%b exp=10", {gnt0, gnt1}); end
    tick(); req0 = 1'b0; m_gnt = 1'b1;
    @(negedge clk);
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin errors++; $display("FAIL fetch_cmd got=%b/%0h exp=1/100", m_req, m_addr); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL fetch_rv1_t1 got=%b exp=0", rv1); end
    tick(); m_gnt = 1'b0;
    @(negedge clk);
    checks++; if ({m_req, rv0, rv1} !== 3'b000) begin errors++; $display("FAIL fetch_wait got=%b exp=000", {m_req, rv0, rv1}); end
    tick(); m_rvalid = 1'b1; m_rdata = 32'h0051_3093;
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b10) begin errors++; $display("FAIL fetch_rvalid got=%b exp=10", {rv0, rv1}); end
    checks++; if (rd0 !== 32'h0051_3093) begin errors++; $display("FAIL fetch_rdata got=%h exp=00513093", rd0); end
    tick(); m_rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2000_0004; wdata1 = 32'hDEAD_BEEF; be1 = 4'b0011;
    @(negedge clk);
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL bp_gnt1 got=%b exp=01", {gnt0, gnt1}); end
    tick(); req1 = 1'b0; addr1 = 32'hFFFF_FFFC; wdata1 = 32'h0; be1 = 4'h0; we1 = 1'b0;
    req0 = 1'b1; addr0 = 32'h40; we0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_gnt = (i == 4);
      @(negedge clk);
      checks++;
      if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000_0004, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b/%b/%h/%h/%h", i, m_req, m_we, m_be, m_addr, m_wdata);
      end
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL bp_no_gnt0[%0d] got=%b exp=0", i, gnt0); end
      tick();
    end
    m_gnt = 1'b0;
    @(negedge clk);
    checks++; if ({gnt0, m_req, rv1} !== 3'b000) begin errors++; $display("FAIL bp_rsp_wait got=%b exp=000", {gnt0, m_req, rv1}); end
    tick(); m_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({gnt0, rv0, rv1} !== 3'b001) begin errors++; $display("FAIL bp_ack got=%b exp=001", {gnt0, rv0, rv1}); end
    tick(); m_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL bp_gnt0_after got=%b exp=1", gnt0); end
    tick(); req0 = 1'b0; m_gnt = 1'b1;
    tick(); m_gnt = 1'b0; m_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b10) begin errors++; $display("FAIL bp_fetch_rsp got=%b exp=10", {rv0, rv1}); end
    tick(); m_rvalid = 1'b0;
  endtask

  task automatic test_reset_rsp();
    req0 = 1'b1; addr0 = 32'h80; we0 = 1'b1; be0 = 4'hf; wdata0 = 32'h55;
    tick(); req0 = 1'b0; m_gnt = 1'b1;
    tick(); m_gnt = 1'b0;
    @(negedge clk);
    rstn = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
    #1;
    checks++; if ({gnt0, gnt1, m_req, rv0, rv1} !== 5'b0) begin errors++; $display("FAIL rst_rsp_ctrl got=%b exp=00000", {gnt0, gnt1, m_req, rv0, rv1}); end
    checks++; if ({m_we, m_be, m_addr, m_wdata} !== 69'd0) begin errors++; $display("FAIL rst_rsp_fields got=%0h exp=0", {m_we, m_be, m_addr, m_wdata}); end
    m_rvalid = 1'b0;
    tick(); rstn = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rst_tie got=%b exp=10", {gnt0, gnt1}); end
    tick(); req0 = 1'b0; req1 = 1'b0; m_gnt = 1'b1;
    tick(); m_gnt = 1'b0; m_rvalid = 1'b1;
    tick(); m_rvalid = 1'b0;
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1; m_rdata = $urandom;
      @(negedge clk);
      checks++; if ({rv0, rv1, m_req} !== 3'b000) begin errors++; $display("FAIL spur_idle[%0d] got=%b exp=000", i, {rv0, rv1, m_req}); end
      tick();
    end
    m_rvalid = 1'b0; req1 = 1'b1; addr1 = 32'h44;
    @(negedge clk);
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL spur_gnt got=%b exp=01", {gnt0, gnt1}); end
    tick(); req1 = 1'b0; m_gnt = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({rv0, rv1, m_req, gnt0, gnt1} !== 5'b0) begin errors++; $display("FAIL spur_rsp[%0d] got=%b exp=00000", i, {rv0, rv1, m_req, gnt0, gnt1}); end
      tick();
    end
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b01 || rd1 !== 32'hCAFE_0001) begin errors++; $display("FAIL spur_ack got=%b/%h exp=01/cafe0001", {rv0, rv1}, rd1); end
    tick(); m_rvalid = 1'b0;
  endtask

  task automatic test_random();
    logic pend[2], fw[2];
    logic [3:0] fb[2];
    logic [31:0] fa[2], fd[2];
    logic last, own, w, any, ew;
    logic [3:0] eb;
    logic [31:0] ea, ed;
    int stage, ntx;
    rstn = 1'b0; tick(); rstn = 1'b1;
    stage = 0; last = 1'b1; own = 1'b0; ntx = 0; ew = 1'b0; eb = '0; ea = '0; ed = '0;
    for (int r = 0; r < 2; r++) begin pend[r] = 1'b0; fw[r] = 1'b0; fb[r] = '0; fa[r] = '0; fd[r] = '0; end
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1; fw[r] = 1'($urandom); fb[r] = 4'($urandom); fa[r] = $urandom; fd[r] = $urandom;
        end else if (pend[r] && stage == 0 && $urandom_range(0, 15) == 0) pend[r] = 1'b0;
      end
      req0 = pend[0]; we0 = fw[0]; be0 = fb[0]; addr0 = fa[0]; wdata0 = fd[0];
      req1 = pend[1]; we1 = fw[1]; be1 = fb[1]; addr1 = fa[1]; wdata1 = fd[1];
      m_rvalid = (stage == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      m_gnt = (stage == 0) ? 1'b0 : (!m_rvalid && $urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      any = pend[0] | pend[1];
      w = (pend[0] && pend[1]) ? ~last : pend[1];
      @(negedge clk);
      if (stage == 0) begin
        checks++; if ({gnt0, gnt1} !== {any && !w, any && w}) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {gnt0, gnt1}, {any && !w, any && w}); end
        checks++; if ({m_req, rv0, rv1} !== 3'b000) begin errors++; $display("FAIL rnd_idle c=%0d got=%b exp=000", c, {m_req, rv0, rv1}); end
      end else if (stage == 1) begin
        checks++;
        if ({m_req, m_we, m_be, m_addr, m_wdata, gnt0, gnt1, rv0, rv1} !== {1'b1, ew, eb, ea, ed, 4'b0000}) begin
          errors++; $display("FAIL rnd_cmd c=%0d got=%b/%b/%h/%h/%h exp=1/%b/%h/%h/%h", c, m_req, m_we, m_be, m_addr, m_wdata, ew, eb, ea, ed);
        end
      end else begin
        checks++;
        if ({m_req, gnt0, gnt1, rv0, rv1} !== {3'b000, m_rvalid && !own, m_rvalid && own}) begin
          errors++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, {m_req, gnt0, gnt1, rv0, rv1}, {3'b000, m_rvalid && !own, m_rvalid && own});
        end
        if (m_rvalid) begin
          checks++; if ((own ? rd1 : rd0) !== m_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, own ? rd1 : rd0, m_rdata); end
        end
      end
      if (stage == 0 && any) begin
        stage = 1; own = w; last = w; ew = fw[w]; eb = fb[w]; ea = fa[w]; ed = fd[w]; pend[w] = 1'b0; ntx++;
      end else if (stage == 1 && m_gnt) stage = 2;
      else if (stage == 2 && m_rvalid) stage = 0;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    checks++; if (ntx < 50) begin errors++; $display("FAIL rnd_progress got=%0d exp>=50", ntx); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_fetch();
    test_backpressure();
    test_reset_rsp();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arb_2.md
# bus_arb_2

Two-requester arbiter sharing the single RV32I memory port between instruction fetch (requester 0) and load/store (requester 1). It picks a winner with round-robin priority, latches the winner's command, and presents it to memory with a req/gnt handshake. It then routes the memory response back to the owning requester. One transaction is outstanding at a time.

## Interface
- DW, 32, data width
- AW, 32, address width
- I_CLK  in  1  clock, all state on rising edge
- I_RSTN  in  1  reset, asynchronous, active-low
- I_REQ0 / I_REQ1  in  1  request from fetch / LSU; held with its fields until granted
- I_WE0 / I_WE1  in  1  write enable
- I_BE0 / I_BE1  in  4  byte enables
- I_ADDR0 / I_ADDR1  in  AW  byte address
- I_WDATA0 / I_WDATA1  in  DW  write data
- O_GNT0 / O_GNT1  out  1  command accepted this cycle
- O_RVALID0 / O_RVALID1  out  1  response for this requester valid this cycle
- O_RDATA0 / O_RDATA1  out  DW  read data
- O_M_REQ  out  1  memory command valid
- O_M_WE, O_M_BE, O_M_ADDR, O_M_WDATA  out  1/4/AW/DW  latched command
- I_M_GNT  in  1  memory accepted command
- I_M_RVALID  in  1  memory response, returned for writes too
- I_M_RDATA  in  DW  memory read data

## Operation
- FSM with three states:
  - IDLE (reset state).
  - CMD: O_M_REQ=1, waiting for I_M_GNT.
  - RSP: waiting for I_M_RVALID.
- Arbitration happens in IDLE only:
  - Exactly one request high: it wins.
  - Both high: the requester not recorded in LAST wins.
  - LAST resets to 1, so fetch wins the first tie.
- On the IDLE edge with a winner:
  - Latch the winner's WE/BE/ADDR/WDATA, selected by I_SEL = winner index.
  - Set OWNER = winner, LAST = winner, go to CMD.
- O_GNTn is combinational: high in IDLE when n wins and I_RSTN=1; low otherwise. It is a single-cycle pulse per transaction.
- CMD: hold O_M_REQ and the latched fields stable until I_M_GNT=1 is sampled, then go to RSP.
- RSP:
  - O_RVALID[OWNER] = I_M_RVALID and O_RDATA[OWNER] = I_M_RDATA, combinationally, zero added latency.
  - The non-owner's O_RVALID is always 0.
  - On I_M_RVALID go to IDLE.
- The requester ignores O_RDATA on write acks.
- O_RDATAn carries I_M_RDATA unconditionally; it is qualified only by O_RVALIDn.
- A request arriving while not IDLE waits. A requester must keep I_REQ asserted until it sees O_GNT.
- Dropping I_REQ before grant is legal; that request is simply not served.
- Memory contract: I_M_RVALID never arrives in the same cycle as I_M_GNT. The arbiter ignores I_M_RVALID outside RSP and I_M_GNT outside CMD.

## Timing
- Reset (async assert, sync-safe deassert):
  - State=IDLE, OWNER=0, LAST=1.
  - Latched WE/BE/ADDR/WDATA = 0.
  - O_M_REQ=0, O_GNT0/1=0, O_RVALID0/1=0.
- Reset mid-transaction: the transaction is abandoned with no response forwarded. The memory is reset together with the arbiter.
- Cycle timeline:
  - Cycle t: IDLE, O_GNTn=1.
  - t+1: O_M_REQ=1.
  - First cycle with I_M_GNT=1 (t+1 at earliest): leave CMD.
  - First I_M_RVALID in RSP (t+2 at earliest): O_RVALIDn.
  - Next cycle: IDLE, where a new grant is possible.
- Minimum of 3 cycles per transaction.
- Fairness: with both requesting continuously, grants strictly alternate.

## Structure
- A shared bus package holds:
  - State encodings ST_IDLE=2'd0, ST_CMD=2'd1, ST_RSP=2'd2.
  - Requester index constants REQ_IF=1'b0, REQ_LS=1'b1.
  - The BE width constant (4).
- Command steering uses four instances of the library 2:1 mux MUX_2:
  - ADDR (DW=AW).
  - WDATA (DW).
  - BE (DW=4).
  - WE (DW=1).
- All instances take I_SEL = winner index.
- No other sub-module. FSM, OWNER and LAST live in bus_arb_2.

## Test plan
- Single fetch: I_REQ0=1, ADDR0=0x0000_0100; memory grants at t+1 and responds with RDATA=0x0051_3093 at t+3. Required:
  - O_GNT0 at t.
  - O_M_ADDR=0x100 at t+1.
  - O_RVALID0 with 0x0051_3093 at t+3; O_RVALID1=0 throughout.
- Tie after reset: I_REQ0=I_REQ1=1 held. Required:
  - Grant order 0,1,0,1.
  - Gap of exactly 3 cycles between grants with zero-wait memory.
- Memory backpressure: LSU write ADDR1=0x2000_0004, WDATA1=0xDEAD_BEEF, BE1=4'b0011, with I_M_GNT low for 4 cycles. Required:
  - O_M_REQ and all latched fields stable for all 5 CMD cycles.
  - A new I_REQ0 is not granted until after the ack.
- Field isolation: change ADDR1 to 0xFFFF_FFFC one cycle after O_GNT1. Required: O_M_ADDR stays at the latched value.
- Reset in RSP: assert I_RSTN=0 while waiting for the response. Required:
  - All outputs are 0 immediately.
  - After release, a tie grants requester 0 first.
- Spurious handshakes: I_M_RVALID=1 in IDLE and I_M_GNT=1 in RSP. Required: no O_RVALID and no state change.
